// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: turns hazard, redirect, memory-stall and halt
// inputs into per-stage load enables / bubbles, with a stall counter and DMEM watchdog.
module pipe_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Reg_haz,
    input  logic             br_taken,
    input  logic             imem_stall,
    input  logic             imem_done,
    input  logic             dmem_stall,
    input  logic             dmem_done,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int TO_W = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_RUN,
        S_IMEM_WAIT,
        S_DMEM_WAIT,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic             squash_q, squash_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             err_q, err_d;

    logic pc_c, ifid_c, idex_c, exmem_c, memwb_c;
    logic flush_c, idex_b_c, memwb_b_c;
    logic run_rules, fetch_wait, squash_hit;

    always_comb begin
        state_d    = state_q;
        squash_d   = squash_q;
        to_cnt_d   = '0;
        err_d      = err_q;
        pc_c       = 1'b0;
        ifid_c     = 1'b0;
        idex_c     = 1'b0;
        exmem_c    = 1'b0;
        memwb_c    = 1'b0;
        flush_c    = 1'b0;
        idex_b_c   = 1'b0;
        memwb_b_c  = 1'b0;
        run_rules  = 1'b0;
        fetch_wait = imem_stall;
        squash_hit = 1'b0;

        unique case (state_q)
            S_RUN: run_rules = 1'b1;
            S_IMEM_WAIT: begin
                run_rules  = 1'b1;
                fetch_wait = imem_stall || !imem_done;
                squash_hit = imem_done && squash_q;
            end
            S_DMEM_WAIT: begin
                if (dmem_done) begin
                    run_rules = 1'b1;
                end else begin
                    memwb_c   = 1'b1;
                    memwb_b_c = 1'b1;
                    if (to_cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_HALTED;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
            S_DRAIN:  state_d = S_HALTED;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase

        if (run_rules) begin
            if (halt_mem && !dmem_stall) begin
                memwb_c = 1'b1;
                state_d = S_DRAIN;
            end else if (dmem_stall) begin
                memwb_c   = 1'b1;
                memwb_b_c = 1'b1;
                state_d   = S_DMEM_WAIT;
            end else begin
                pc_c    = 1'b1;
                ifid_c  = 1'b1;
                idex_c  = 1'b1;
                exmem_c = 1'b1;
                memwb_c = 1'b1;
                state_d = fetch_wait ? S_IMEM_WAIT : S_RUN;
                if (br_taken) begin
                    flush_c  = 1'b1;
                    idex_b_c = 1'b1;
                    // Only an outstanding fetch can return a wrong-path word.
                    squash_d = fetch_wait;
                end else if (fetch_wait || squash_hit) begin
                    pc_c = 1'b0;
                    if (Reg_haz) begin
                        ifid_c   = 1'b0;
                        idex_b_c = 1'b1;
                    end else begin
                        flush_c = 1'b1;
                    end
                    if (squash_hit) squash_d = 1'b0;
                end else if (Reg_haz) begin
                    pc_c     = 1'b0;
                    ifid_c   = 1'b0;
                    idex_b_c = 1'b1;
                end
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_c && state_q != S_DRAIN && state_q != S_HALTED && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            squash_q    <= 1'b0;
            to_cnt_q    <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            squash_q    <= squash_d;
            to_cnt_q    <= to_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign pc_en        = pc_c      & ~rst;
    assign ifid_en      = ifid_c    & ~rst;
    assign idex_en      = idex_c    & ~rst;
    assign exmem_en     = exmem_c   & ~rst;
    assign memwb_en     = memwb_c   & ~rst;
    assign ifid_flush   = flush_c   & ~rst;
    assign idex_bubble  = idex_b_c  & ~rst;
    assign memwb_bubble = memwb_b_c & ~rst;
    assign halted       = (state_q == S_HALTED) & ~rst;
    assign err          = err_q & ~rst;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance plus a CNT_W=3 / TIMEOUT=4 instance
// sharing the same stimulus.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, Reg_haz, br_taken, imem_stall, imem_done, dmem_stall, dmem_done, halt_mem;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_bubble, memwb_bubble, halted, err;
    logic [15:0] stall_cnt;

    logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic s_ifid_flush, s_idex_bubble, s_memwb_bubble, s_halted, s_err;
    logic [2:0] s_stall_cnt;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .Reg_haz(Reg_haz), .br_taken(br_taken),
        .imem_stall(imem_stall), .imem_done(imem_done),
        .dmem_stall(dmem_stall), .dmem_done(dmem_done), .halt_mem(halt_mem),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .memwb_bubble(memwb_bubble), .halted(halted), .err(err), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.CNT_W(3), .TIMEOUT(4)) dut_s (
        .clk(clk), .rst(rst), .Reg_haz(Reg_haz), .br_taken(br_taken),
        .imem_stall(imem_stall), .imem_done(imem_done),
        .dmem_stall(dmem_stall), .dmem_done(dmem_done), .halt_mem(halt_mem),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
        .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
        .memwb_bubble(s_memwb_bubble), .halted(s_halted), .err(s_err), .stall_cnt(s_stall_cnt)
    );

    // {pc, ifid, idex, exmem, memwb, flush, idex_bubble, memwb_bubble, halted, err}
    logic [9:0] ctl, s_ctl;
    assign ctl   = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_bubble, memwb_bubble, halted, err};
    assign s_ctl = {s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en,
                    s_ifid_flush, s_idex_bubble, s_memwb_bubble, s_halted, s_err};

    // Stimulus: {rst, Reg_haz, br_taken, imem_stall, imem_done, dmem_stall, dmem_done, halt_mem}
    localparam logic [7:0] IDLE = 8'h00, RST = 8'h80, HAZ = 8'h40, BR = 8'h20, IS = 8'h10;
    localparam logic [7:0] ID = 8'h08, DS = 8'h04, DD = 8'h02, HM = 8'h01;

    localparam logic [9:0] C_ALL1 = 10'b11111_000_00;
    localparam logic [9:0] C_HAZ  = 10'b00111_010_00;
    localparam logic [9:0] C_BR   = 10'b11111_110_00;
    localparam logic [9:0] C_IS   = 10'b01111_100_00;
    localparam logic [9:0] C_DS   = 10'b00001_001_00;
    localparam logic [9:0] C_HM   = 10'b00001_000_00;
    localparam logic [9:0] C_ZERO = 10'b00000_000_00;
    localparam logic [9:0] C_HALT = 10'b00000_000_10;
    localparam logic [9:0] C_WD   = 10'b00000_000_11;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply a vector just after the rising edge, return at the following falling edge.
    task automatic drive(input logic [7:0] v);
        @(posedge clk);
        #1;
        {rst, Reg_haz, br_taken, imem_stall, imem_done, dmem_stall, dmem_done, halt_mem} = v;
        @(negedge clk);
        $display("t=%0t in=%b ctl=%b stall_cnt=%0d | s_ctl=%b s_stall_cnt=%0d",
                 $time, v, ctl, stall_cnt, s_ctl, s_stall_cnt);
    endtask

    initial begin
        {rst, Reg_haz, br_taken, imem_stall, imem_done, dmem_stall, dmem_done, halt_mem} = RST;

        // Reset
        drive(RST);
        drive(RST);
        chk("rst_ctl", 32'(ctl), 32'(C_ZERO));
        chk("rst_stall_cnt", 32'(stall_cnt), 0);

        // Register hazard for two cycles
        drive(HAZ);
        chk("haz1_ctl", 32'(ctl), 32'(C_HAZ));
        chk("haz1_cnt", 32'(stall_cnt), 0);
        drive(HAZ);
        chk("haz2_ctl", 32'(ctl), 32'(C_HAZ));
        drive(IDLE);
        chk("haz_end_ctl", 32'(ctl), 32'(C_ALL1));
        chk("haz_end_cnt", 32'(stall_cnt), 2);

        // Branch overrides hazard
        drive(BR | HAZ);
        chk("br_haz_ctl", 32'(ctl), 32'(C_BR));
        drive(IDLE);
        chk("br_haz_cnt", 32'(stall_cnt), 2);

        // Fetch stall with branch mid-wait, squashed return
        drive(IS);
        chk("is1_ctl", 32'(ctl), 32'(C_IS));
        drive(IS | BR);
        chk("is2_br_ctl", 32'(ctl), 32'(C_BR));
        drive(IS);
        chk("is3_ctl", 32'(ctl), 32'(C_IS));
        drive(ID);
        chk("squash_ctl", 32'(ctl), 32'(C_IS));
        chk("squash_cnt", 32'(stall_cnt), 4);
        drive(IDLE);
        chk("post_squash_ctl", 32'(ctl), 32'(C_ALL1));
        chk("post_squash_cnt", 32'(stall_cnt), 5);

        // Data stall for 5 cycles; the TIMEOUT=4 instance trips its watchdog
        for (int i = 0; i < 5; i++) begin
            drive(DS);
            chk($sformatf("ds%0d_ctl", i), 32'(ctl), 32'(C_DS));
            chk($sformatf("ds%0d_s_ctl", i), 32'(s_ctl), 32'(C_DS));
        end
        drive(DD);
        chk("dd_ctl", 32'(ctl), 32'(C_ALL1));
        chk("dd_cnt", 32'(stall_cnt), 10);
        chk("wd_s_ctl", 32'(s_ctl), 32'(C_WD));
        chk("wd_s_cnt_sat", 32'(s_stall_cnt), 7);
        drive(IDLE);
        chk("post_dd_ctl", 32'(ctl), 32'(C_ALL1));
        chk("post_dd_cnt", 32'(stall_cnt), 10);
        chk("wd_s_sticky", 32'(s_ctl), 32'(C_WD));

        // Halt in RUN
        drive(HM | HAZ | BR);
        chk("halt_ctl", 32'(ctl), 32'(C_HM));
        drive(IDLE);
        chk("drain_ctl", 32'(ctl), 32'(C_ZERO));
        drive(IDLE);
        chk("halted1_ctl", 32'(ctl), 32'(C_HALT));
        drive(HAZ | IS);
        chk("halted2_ctl", 32'(ctl), 32'(C_HALT));
        chk("halted_cnt", 32'(stall_cnt), 11);

        // Reset out of HALTED
        drive(RST);
        chk("rst_halt_ctl", 32'(ctl), 32'(C_ZERO));
        drive(IDLE);
        chk("after_rst_ctl", 32'(ctl), 32'(C_ALL1));
        chk("after_rst_cnt", 32'(stall_cnt), 0);

        // Halt deferred behind a data access
        drive(HM | DS);
        chk("halt_ds_ctl", 32'(ctl), 32'(C_DS));
        drive(HM | DD);
        chk("halt_dd_ctl", 32'(ctl), 32'(C_HM));
        drive(IDLE);
        chk("halt_dd_drain", 32'(ctl), 32'(C_ZERO));
        drive(IDLE);
        chk("halt_dd_halted", 32'(ctl), 32'(C_HALT));
        drive(RST);

        // Simultaneous fetch and data stall: data side first, fetch re-sampled after
        drive(IS | DS);
        chk("dual_ctl", 32'(ctl), 32'(C_DS));
        drive(IS | DD);
        chk("dual_done_ctl", 32'(ctl), 32'(C_IS));
        drive(ID);
        chk("dual_fetch_ctl", 32'(ctl), 32'(C_ALL1));
        chk("dual_cnt", 32'(stall_cnt), 2);
        drive(RST);

        // Saturation of the 3-bit counter
        for (int i = 0; i < 10; i++) drive(HAZ);
        chk("sat_haz_ctl", 32'(ctl), 32'(C_HAZ));
        drive(IDLE);
        chk("sat_s_cnt", 32'(s_stall_cnt), 7);
        chk("sat_cnt", 32'(stall_cnt), 10);
        chk("sat_s_ctl", 32'(s_ctl), 32'(C_ALL1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
